// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
//   state_t        : sequencer FSM states
//   TT_*           : reference truth tables, bit i = Y for {A,B}=i
//   NUM_VEC        : number of input vectors swept per pass
package gate_seq_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  localparam int NUM_VEC = 4;

endpackage

// File: rtl/gate_seq_hold_cnt.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled, wrapping to 0 after
// the terminal count.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : advance the count
//   tc       : count == HOLD_CYCLES-1
module gate_seq_hold_cnt #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] count;

  assign tc = (count == CW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/gate_truth_sequencer.sv
// Clocked truth-table checker for a 2-input gate. Drives {A,B} through
// 00,01,10,11, holding each vector HOLD_CYCLES clocks, samples Y on the last
// hold cycle of each vector and compares the 4-bit table to EXPECTED.
//   clk, rst          : clock, async active-high reset
//   start             : begin a sweep (only honoured in IDLE)
//   A, B              : registered gate stimulus
//   Y                 : gate output under test
//   busy              : sweep in progress (DRIVE or DONE)
//   done              : one-cycle pulse at sweep end
//   pass              : truth == EXPECTED for last completed sweep
//   truth             : captured table, bit i = Y for {A,B}=i
//   vec_idx           : current vector index ({A,B})
// Optional (GATE_SEQ_FAIL_IDX_EN):
//   first_fail_vld/idx: sticky index of the first mismatching vector
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] EXPECTED    = TT_NAND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] truth,
  output logic [1:0] vec_idx
`ifdef GATE_SEQ_FAIL_IDX_EN
  ,
  output logic       first_fail_vld,
  output logic [1:0] first_fail_idx
`endif
);

  state_t     state;
  logic       hold_tc;
  logic       last_vec;
  logic [3:0] truth_nxt;

  // Counter runs only in DRIVE; held at zero elsewhere so each sweep starts
  // with a full hold on vector 0.
  gate_seq_hold_cnt #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != DRIVE),
    .en  (state == DRIVE),
    .tc  (hold_tc)
  );

  assign last_vec = (vec_idx == 2'(NUM_VEC - 1));

  // Table with the current sample merged, so pass can be registered on the
  // same edge that captures the final vector.
  always_comb begin
    truth_nxt          = truth;
    truth_nxt[vec_idx] = Y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      A       <= 1'b0;
      B       <= 1'b0;
      vec_idx <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      truth   <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          A       <= 1'b0;
          B       <= 1'b0;
          vec_idx <= 2'd0;
          busy    <= 1'b0;
          if (start) begin
            state <= DRIVE;
            busy  <= 1'b1;
            truth <= 4'b0000;
          end
        end
        DRIVE: begin
          if (hold_tc) begin
            truth <= truth_nxt;
            if (last_vec) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (truth_nxt == EXPECTED);
            end else begin
              vec_idx  <= vec_idx + 2'd1;
              {A, B}   <= vec_idx + 2'd1;
            end
          end
        end
        DONE: begin
          // A/B stay at 11 through DONE, then return to 00.
          state   <= IDLE;
          busy    <= 1'b0;
          A       <= 1'b0;
          B       <= 1'b0;
          vec_idx <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_SEQ_FAIL_IDX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= 2'd0;
    end else if (state == IDLE && start) begin
      first_fail_vld <= 1'b0;
      first_fail_idx <= 2'd0;
    end else if (state == DRIVE && hold_tc && !first_fail_vld &&
                 (Y != EXPECTED[vec_idx])) begin
      first_fail_vld <= 1'b1;
      first_fail_idx <= vec_idx;
    end
  end
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
module tb_gate_truth_sequencer;
  import gate_seq_pkg::*;

  localparam int H = 10;

  logic clk, rst;
  logic start, start1;
  logic gate_sel;  // 0: NAND attached, 1: AND attached
  logic A, B, Y, busy, done, pass;
  logic [3:0] truth;
  logic [1:0] vec_idx;
  logic A1, B1, Y1, busy1, done1, pass1;
  logic [3:0] truth1;
  logic [1:0] vec_idx1;
`ifdef GATE_SEQ_FAIL_IDX_EN
  logic ff_vld, ff_vld1;
  logic [1:0] ff_idx, ff_idx1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  assign Y  = gate_sel ? (A & B) : ~(A & B);
  assign Y1 = ~(A1 & B1);

  gate_truth_sequencer #(.HOLD_CYCLES(H), .EXPECTED(TT_NAND)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Y(Y),
    .busy(busy), .done(done), .pass(pass), .truth(truth), .vec_idx(vec_idx)
`ifdef GATE_SEQ_FAIL_IDX_EN
    , .first_fail_vld(ff_vld), .first_fail_idx(ff_idx)
`endif
  );

  gate_truth_sequencer #(.HOLD_CYCLES(1), .EXPECTED(TT_NAND)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Y(Y1),
    .busy(busy1), .done(done1), .pass(pass1), .truth(truth1), .vec_idx(vec_idx1)
`ifdef GATE_SEQ_FAIL_IDX_EN
    , .first_fail_vld(ff_vld1), .first_fail_idx(ff_idx1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; gate_sel = 1'b0;
    #12;
    n_chk++;
    if ({A, B, busy, done, pass, truth, vec_idx} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state got A=%b B=%b busy=%b done=%b pass=%b truth=%b vec=%0d want all 0",
               A, B, busy, done, pass, truth, vec_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 4*H; c++) begin
      n_chk++;
      if ({A, B} !== 2'((c-1)/H) || vec_idx !== 2'((c-1)/H) || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL nominal_vec cycle %0d got AB=%b%b vec=%0d done=%b busy=%b want vec=%0d done=0 busy=1",
                 c, A, B, vec_idx, done, busy, (c-1)/H);
      end
      tick();
    end
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b1 || truth !== 4'b0111 || pass !== 1'b1 || {A, B} !== 2'b11) begin
      n_fail++;
      $display("FAIL nominal_done got done=%b busy=%b truth=%b pass=%b AB=%b%b want 1 1 0111 1 11",
               done, busy, truth, pass, A, B);
    end
`ifdef GATE_SEQ_FAIL_IDX_EN
    n_chk++;
    if (ff_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_ff_vld got %b want 0", ff_vld);
    end
`endif
    tick();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || {A, B} !== 2'b00 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_after got done=%b busy=%b AB=%b%b pass=%b want 0 0 00 1", done, busy, A, B, pass);
    end
  endtask

  task automatic test_wrong_gate();
    gate_sel = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 4*H; c++) tick();
    n_chk++;
    if (done !== 1'b1 || truth !== 4'b1000 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL wrong_gate got done=%b truth=%b pass=%b want 1 1000 0", done, truth, pass);
    end
`ifdef GATE_SEQ_FAIL_IDX_EN
    n_chk++;
    if (ff_vld !== 1'b1 || ff_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL wrong_gate_ff got vld=%b idx=%0d want 1 0", ff_vld, ff_idx);
    end
`endif
    tick();
    gate_sel = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int n_done = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 4*H; c++) begin
      start = (c == 15);
      if (done === 1'b1) n_done++;
      n_chk++;
      if (vec_idx !== 2'((c-1)/H)) begin
        n_fail++;
        $display("FAIL busy_vec cycle %0d got %0d want %0d", c, vec_idx, (c-1)/H);
      end
      tick();
    end
    start = 1'b0;
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b1 || truth !== 4'b0111) begin
      n_fail++;
      $display("FAIL busy_done got done=%b pass=%b truth=%b want 1 1 0111", done, pass, truth);
    end
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    n_chk++;
    if (n_done != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_one_done got %0d pulses busy=%b want 1 pulse busy=0", n_done, busy);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c < 25; c++) tick();
    n_chk++;
    if (vec_idx !== 2'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre got vec=%0d busy=%b want 2 1", vec_idx, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (A !== 1'b0 || B !== 1'b0 || busy !== 1'b0 || truth !== 4'b0000 || vec_idx !== 2'd0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async got A=%b B=%b busy=%b truth=%b vec=%0d pass=%b want all 0",
               A, B, busy, truth, vec_idx, pass);
    end
    #1 rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 4*H; c++) begin
      n_chk++;
      if (done !== 1'b0 || {A, B} !== 2'((c-1)/H)) begin
        n_fail++;
        $display("FAIL midrst_sweep cycle %0d got done=%b AB=%b%b want 0 %0d", c, done, A, B, (c-1)/H);
      end
      tick();
    end
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b1 || truth !== 4'b0111) begin
      n_fail++;
      $display("FAIL midrst_done got done=%b pass=%b truth=%b want 1 1 0111", done, pass, truth);
    end
    tick();
  endtask

  task automatic test_hold_one();
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_chk++;
      if ({A1, B1} !== 2'(c-1) || done1 !== 1'b0 || busy1 !== 1'b1) begin
        n_fail++;
        $display("FAIL h1_vec cycle %0d got AB=%b%b done=%b busy=%b want %0d 0 1", c, A1, B1, done1, busy1, c-1);
      end
      tick();
    end
    n_chk++;
    if (done1 !== 1'b1 || truth1 !== 4'b0111 || pass1 !== 1'b1) begin
      n_fail++;
      $display("FAIL h1_done got done=%b truth=%b pass=%b want 1 0111 1", done1, truth1, pass1);
    end
    tick();
    n_chk++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL h1_after got done=%b busy=%b want 0 0", done1, busy1);
    end
  endtask

  task automatic test_continuous();
    int prev = -1;
    int n_done = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        n_chk++;
        if (pass !== 1'b1 || (prev >= 0 && cyc - prev != 4*H + 2)) begin
          n_fail++;
          $display("FAIL cont_period got gap=%0d pass=%b want %0d 1", cyc - prev, pass, 4*H + 2);
        end
        prev = cyc;
      end
    end
    start = 1'b0;
    n_chk++;
    if (n_done != 3) begin
      n_fail++;
      $display("FAIL cont_count got %0d done pulses want 3", n_done);
    end
    for (int c = 0; c < 60 && busy !== 1'b0; c++) tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_idle timeout busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wrong_gate();
    test_start_while_busy();
    test_reset_mid();
    test_hold_one();
    test_continuous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
